// File: rtl/rv_dmem_port.sv
// rv_dmem_port: execute-to-writeback data memory port.
// Aligns stores, runs req/ack bus cycles, holds results for writeback.
module rv_dmem_port #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        x_req_i,
   input  logic        x_load_i,
   input  logic [2:0]  x_fun_i,
   input  logic [31:0] x_addr_i,
   input  logic [31:0] x_store_data_i,
   input  logic        w_stall_i,
   output logic [31:0] dm_addr_o,
   output logic [31:0] dm_data_s_o,
   output logic [3:0]  dm_data_select_o,
   output logic        dm_load_o,
   output logic        dm_store_o,
   input  logic        dm_ack_i,
   input  logic [31:0] dm_data_l_i,
   output logic [31:0] dm_data_l_o,
   output logic        dm_load_done_o,
   output logic        dm_store_done_o,
   output logic        dm_err_o
);

   localparam logic [2:0] LDST_B  = 3'b000;
   localparam logic [2:0] LDST_H  = 3'b001;
   localparam logic [2:0] LDST_L  = 3'b010;
   localparam logic [2:0] LDST_BU = 3'b100;
   localparam logic [2:0] LDST_HU = 3'b101;

   localparam int unsigned CW =
      (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_ACK = 2'd1,
      DONE     = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   sdata_q, sdata_d;
   logic [3:0]    sel_q, sel_d;
   logic          load_q, load_d;
   logic          err_q, err_d;
   logic [31:0]   ldata_q, ldata_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          is_byte;
   logic          is_half;
   logic          misalign;
   logic          expire;
   logic [31:0]   fmt_data;
   logic [3:0]    fmt_sel;

   always_comb begin
      is_byte = 1'b0;
      is_half = 1'b0;
      unique case (x_fun_i)
         LDST_B, LDST_BU: is_byte = 1'b1;
         LDST_H, LDST_HU: is_half = 1'b1;
         LDST_L:          ;
         default:         ;
      endcase
   end

   assign misalign = (is_half & x_addr_i[0])
                   | (!is_byte & !is_half & (x_addr_i[1:0] != 2'b00));

   // Lanes are replicated so the bus can pick any byte via selects.
   always_comb begin
      fmt_data = x_store_data_i;
      fmt_sel  = 4'b1111;
      if (x_load_i) begin
         fmt_data = '0;
      end else if (is_byte) begin
         fmt_data = {4{x_store_data_i[7:0]}};
         fmt_sel  = 4'b0001 << x_addr_i[1:0];
      end else if (is_half) begin
         fmt_data = {2{x_store_data_i[15:0]}};
         fmt_sel  = x_addr_i[1] ? 4'b1100 : 4'b0011;
      end
   end

   assign expire = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      sdata_d = sdata_q;
      sel_d   = sel_q;
      load_d  = load_q;
      err_d   = err_q;
      ldata_d = ldata_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (x_req_i) begin
               addr_d  = {x_addr_i[31:2], 2'b00};
               sdata_d = fmt_data;
               sel_d   = fmt_sel;
               load_d  = x_load_i;
               cnt_d   = '0;
               if (misalign) begin
                  state_d = DONE;
                  err_d   = 1'b1;
                  ldata_d = '0;
               end else begin
                  state_d = WAIT_ACK;
               end
            end
         end
         WAIT_ACK: begin
            cnt_d = (TIMEOUT_CYCLES == 0) ? '0 : cnt_q + 1'b1;
            // Ack is checked first so it beats a same-cycle expiry.
            if (dm_ack_i) begin
               state_d = DONE;
               if (load_q) ldata_d = dm_data_l_i;
            end else if (expire) begin
               state_d = DONE;
               err_d   = 1'b1;
               ldata_d = '0;
            end
         end
         DONE: begin
            if (!w_stall_i) begin
               state_d = IDLE;
               err_d   = 1'b0;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            err_d   = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         addr_q  <= '0;
         sdata_q <= '0;
         sel_q   <= '0;
         load_q  <= 1'b0;
         err_q   <= 1'b0;
         ldata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         sdata_q <= sdata_d;
         sel_q   <= sel_d;
         load_q  <= load_d;
         err_q   <= err_d;
         ldata_q <= ldata_d;
         cnt_q   <= cnt_d;
      end
   end

   assign dm_addr_o        = addr_q;
   assign dm_data_s_o      = sdata_q;
   assign dm_data_select_o = sel_q;
   assign dm_load_o        = (state_q == WAIT_ACK) & load_q;
   assign dm_store_o       = (state_q == WAIT_ACK) & !load_q;
   assign dm_load_done_o   = (state_q == DONE) & load_q;
   assign dm_store_done_o  = (state_q == DONE) & !load_q;
   assign dm_err_o         = err_q;
   assign dm_data_l_o      = ldata_q;

endmodule

// File: tb/tb_rv_dmem_port.sv
// tb_rv_dmem_port: directed bench for rv_dmem_port.
// Small timeout so expiry paths are reachable quickly.
module tb_rv_dmem_port;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        x_req = 1'b0;
   logic        x_load = 1'b0;
   logic [2:0]  x_fun = 3'b000;
   logic [31:0] x_addr = '0;
   logic [31:0] x_sd = '0;
   logic        w_stall = 1'b0;
   logic        dm_ack = 1'b0;
   logic [31:0] dm_dl_in = '0;
   logic [31:0] dm_addr;
   logic [31:0] dm_ds;
   logic [3:0]  dm_sel;
   logic        dm_load;
   logic        dm_store;
   logic [31:0] dm_dl;
   logic        ld_done;
   logic        st_done;
   logic        dm_err;

   int checks = 0;
   int errors = 0;

   rv_dmem_port #(.TIMEOUT_CYCLES(4)) dut (
      .clk_i            (clk),
      .rst_n_i          (rst_n),
      .x_req_i          (x_req),
      .x_load_i         (x_load),
      .x_fun_i          (x_fun),
      .x_addr_i         (x_addr),
      .x_store_data_i   (x_sd),
      .w_stall_i        (w_stall),
      .dm_addr_o        (dm_addr),
      .dm_data_s_o      (dm_ds),
      .dm_data_select_o (dm_sel),
      .dm_load_o        (dm_load),
      .dm_store_o       (dm_store),
      .dm_ack_i         (dm_ack),
      .dm_data_l_i      (dm_dl_in),
      .dm_data_l_o      (dm_dl),
      .dm_load_done_o   (ld_done),
      .dm_store_done_o  (st_done),
      .dm_err_o         (dm_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: sim time %0t exceeded limit", $time);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic ld, input logic [2:0] fun,
                        input logic [31:0] a, input logic [31:0] d);
      x_req  = 1'b1;
      x_load = ld;
      x_fun  = fun;
      x_addr = a;
      x_sd   = d;
      tick();
      x_req  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++; if (dm_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h exp 0", dm_addr); end
      checks++; if (dm_ds !== 32'h0) begin errors++; $display("FAIL rst_ds: got %h exp 0", dm_ds); end
      checks++; if (dm_sel !== 4'h0) begin errors++; $display("FAIL rst_sel: got %b exp 0000", dm_sel); end
      checks++; if ({dm_load, dm_store} !== 2'b00) begin errors++; $display("FAIL rst_req: got %b exp 00", {dm_load, dm_store}); end
      checks++; if ({ld_done, st_done, dm_err} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b exp 000", {ld_done, st_done, dm_err}); end
      checks++; if (dm_dl !== 32'h0) begin errors++; $display("FAIL rst_dl: got %h exp 0", dm_dl); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_store_word();
      issue(1'b0, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
      for (int i = 0; i < 3; i++) begin
         checks++; if (dm_store !== 1'b1 || dm_load !== 1'b0) begin errors++; $display("FAIL sw_req c%0d: got st=%b ld=%b exp st=1 ld=0", i, dm_store, dm_load); end
         checks++; if (dm_sel !== 4'b1111 || dm_ds !== 32'hDEAD_BEEF || dm_addr !== 32'h100) begin errors++; $display("FAIL sw_bus c%0d: got sel=%b d=%h a=%h exp 1111 deadbeef 100", i, dm_sel, dm_ds, dm_addr); end
         if (i == 2) dm_ack = 1'b1;
         tick();
      end
      dm_ack = 1'b0;
      checks++; if (dm_store !== 1'b0) begin errors++; $display("FAIL sw_drop: got %b exp 0", dm_store); end
      checks++; if ({st_done, ld_done, dm_err} !== 3'b100) begin errors++; $display("FAIL sw_done: got %b exp 100", {st_done, ld_done, dm_err}); end
      tick();
      checks++; if (st_done !== 1'b0) begin errors++; $display("FAIL sw_clear: got %b exp 0", st_done); end
   endtask

   task automatic test_load_byte();
      issue(1'b1, 3'b000, 32'h0000_0203, 32'h0);
      checks++; if (dm_addr !== 32'h200 || dm_load !== 1'b1 || dm_sel !== 4'b1111) begin errors++; $display("FAIL lb_req: got a=%h ld=%b sel=%b exp 200 1 1111", dm_addr, dm_load, dm_sel); end
      dm_ack   = 1'b1;
      dm_dl_in = 32'h8011_2233;
      tick();
      dm_ack   = 1'b0;
      dm_dl_in = 32'h0;
      checks++; if (ld_done !== 1'b1 || dm_err !== 1'b0 || dm_load !== 1'b0) begin errors++; $display("FAIL lb_done: got done=%b err=%b ld=%b exp 1 0 0", ld_done, dm_err, dm_load); end
      checks++; if (dm_dl !== 32'h8011_2233) begin errors++; $display("FAIL lb_data: got %h exp 80112233", dm_dl); end
      tick();
      checks++; if (ld_done !== 1'b0) begin errors++; $display("FAIL lb_clear: got %b exp 0", ld_done); end
   endtask

   task automatic test_store_lanes();
      logic [2:0]  fun  [3] = '{3'b000, 3'b000, 3'b001};
      logic [31:0] adr  [3] = '{32'h3, 32'h1_0001, 32'h102};
      logic [31:0] dat  [3] = '{32'h1234_56A5, 32'hFFFF_FF3C, 32'h1234_BEEF};
      logic [31:0] eds  [3] = '{32'hA5A5_A5A5, 32'h3C3C_3C3C, 32'hBEEF_BEEF};
      logic [3:0]  esel [3] = '{4'b1000, 4'b0010, 4'b1100};
      logic [31:0] eadr [3] = '{32'h0, 32'h1_0000, 32'h100};
      for (int i = 0; i < 3; i++) begin
         issue(1'b0, fun[i], adr[i], dat[i]);
         checks++; if (dm_ds !== eds[i] || dm_sel !== esel[i] || dm_addr !== eadr[i] || dm_store !== 1'b1) begin errors++; $display("FAIL lane%0d: got d=%h sel=%b a=%h st=%b exp %h %b %h 1", i, dm_ds, dm_sel, dm_addr, dm_store, eds[i], esel[i], eadr[i]); end
         dm_ack = 1'b1;
         tick();
         dm_ack = 1'b0;
         checks++; if (st_done !== 1'b1 || dm_err !== 1'b0) begin errors++; $display("FAIL lane%0d_done: got %b err=%b exp 1 0", i, st_done, dm_err); end
         tick();
      end
   endtask

   task automatic test_misaligned();
      issue(1'b1, 3'b001, 32'h0000_0101, 32'h0);
      checks++; if (dm_load !== 1'b0 || dm_store !== 1'b0) begin errors++; $display("FAIL lh_mis_req: got ld=%b st=%b exp 0 0", dm_load, dm_store); end
      checks++; if (ld_done !== 1'b1 || dm_err !== 1'b1) begin errors++; $display("FAIL lh_mis_done: got done=%b err=%b exp 1 1", ld_done, dm_err); end
      tick();
      checks++; if (ld_done !== 1'b0 || dm_err !== 1'b0) begin errors++; $display("FAIL lh_mis_clear: got done=%b err=%b exp 0 0", ld_done, dm_err); end
      issue(1'b0, 3'b010, 32'h0000_0102, 32'h1);
      checks++; if (dm_store !== 1'b0 || st_done !== 1'b1 || dm_err !== 1'b1) begin errors++; $display("FAIL sw_mis: got st=%b done=%b err=%b exp 0 1 1", dm_store, st_done, dm_err); end
      tick();
      issue(1'b1, 3'b101, 32'h0000_0102, 32'h0);
      checks++; if (dm_load !== 1'b1 || dm_err !== 1'b0) begin errors++; $display("FAIL lhu_ok: got ld=%b err=%b exp 1 0", dm_load, dm_err); end
      dm_ack = 1'b1;
      tick();
      dm_ack = 1'b0;
      tick();
   endtask

   task automatic test_stall_hold();
      w_stall = 1'b1;
      issue(1'b1, 3'b010, 32'h0000_0040, 32'h0);
      dm_ack   = 1'b1;
      dm_dl_in = 32'hCAFE_F00D;
      x_req    = 1'b1;
      x_addr   = 32'h0000_0080;
      tick();
      dm_ack   = 1'b0;
      dm_dl_in = 32'h0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (ld_done !== 1'b1 || dm_dl !== 32'hCAFE_F00D) begin errors++; $display("FAIL stall_hold c%0d: got done=%b d=%h exp 1 cafef00d", i, ld_done, dm_dl); end
         checks++; if (dm_load !== 1'b0 || dm_addr !== 32'h40) begin errors++; $display("FAIL stall_noreq c%0d: got ld=%b a=%h exp 0 40", i, dm_load, dm_addr); end
         tick();
      end
      w_stall = 1'b0;
      x_req   = 1'b0;
      checks++; if (ld_done !== 1'b1) begin errors++; $display("FAIL stall_last: got %b exp 1", ld_done); end
      tick();
      checks++; if (ld_done !== 1'b0 || dm_load !== 1'b0) begin errors++; $display("FAIL stall_clear: got done=%b ld=%b exp 0 0", ld_done, dm_load); end
      tick();
      checks++; if (dm_load !== 1'b0 || dm_addr !== 32'h40) begin errors++; $display("FAIL stall_idle: got ld=%b a=%h exp 0 40", dm_load, dm_addr); end
   endtask

   task automatic test_timeout();
      issue(1'b1, 3'b010, 32'h0000_0300, 32'h0);
      for (int i = 0; i < 4; i++) begin
         checks++; if (dm_load !== 1'b1) begin errors++; $display("FAIL to_req c%0d: got %b exp 1", i, dm_load); end
         tick();
      end
      checks++; if (dm_load !== 1'b0 || ld_done !== 1'b1 || dm_err !== 1'b1) begin errors++; $display("FAIL to_abort: got ld=%b done=%b err=%b exp 0 1 1", dm_load, ld_done, dm_err); end
      checks++; if (dm_dl !== 32'h0) begin errors++; $display("FAIL to_data: got %h exp 0", dm_dl); end
      tick();
      checks++; if (dm_err !== 1'b0 || ld_done !== 1'b0) begin errors++; $display("FAIL to_clear: got err=%b done=%b exp 0 0", dm_err, ld_done); end
      issue(1'b1, 3'b010, 32'h0000_0304, 32'h0);
      for (int i = 0; i < 4; i++) begin
         checks++; if (dm_load !== 1'b1) begin errors++; $display("FAIL to_ack_req c%0d: got %b exp 1", i, dm_load); end
         if (i == 3) begin
            dm_ack   = 1'b1;
            dm_dl_in = 32'h1111_2222;
         end
         tick();
      end
      dm_ack   = 1'b0;
      dm_dl_in = 32'h0;
      checks++; if (ld_done !== 1'b1 || dm_err !== 1'b0 || dm_dl !== 32'h1111_2222) begin errors++; $display("FAIL to_ack_wins: got done=%b err=%b d=%h exp 1 0 11112222", ld_done, dm_err, dm_dl); end
      tick();
   endtask

   task automatic test_reset_mid();
      issue(1'b1, 3'b010, 32'h0000_0400, 32'h0);
      checks++; if (dm_load !== 1'b1) begin errors++; $display("FAIL rm_req: got %b exp 1", dm_load); end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++; if (dm_load !== 1'b0 || dm_addr !== 32'h0 || dm_sel !== 4'h0 || dm_dl !== 32'h0) begin errors++; $display("FAIL rm_rst: got ld=%b a=%h sel=%b d=%h exp 0 0 0 0", dm_load, dm_addr, dm_sel, dm_dl); end
      tick();
      dm_ack   = 1'b1;
      dm_dl_in = 32'h5555_AAAA;
      tick();
      dm_ack   = 1'b0;
      dm_dl_in = 32'h0;
      checks++; if ({ld_done, st_done, dm_err, dm_load} !== 4'b0000 || dm_dl !== 32'h0) begin errors++; $display("FAIL rm_ack_ign: got flags=%b d=%h exp 0000 0", {ld_done, st_done, dm_err, dm_load}, dm_dl); end
      tick();
      checks++; if ({ld_done, st_done, dm_err} !== 3'b000) begin errors++; $display("FAIL rm_idle: got %b exp 000", {ld_done, st_done, dm_err}); end
   endtask

   initial begin
      test_reset();
      test_store_word();
      test_load_byte();
      test_store_lanes();
      test_misaligned();
      test_stall_hold();
      test_timeout();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
